fact_search: RTL and testbench

FACT_SEARCH -- requirements
Module: fact_search

---
 rtl/fact_search.sv | 139 +++++++++++++
 tb/tb_fact_search.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fact_search.sv
// Searches for the first nontrivial factor pair (2 <= i1 <= i2 <= 15) of an 8-bit value, one candidate per cycle.
// Optional pruning of over-large products is enabled by FACT_SEARCH_EARLY_EXIT_EN.
module fact_search (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_found,
  output logic [3:0] rsp_i1,
  output logic [3:0] rsp_i2,
  output logic [6:0] rsp_count,
  output logic       busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 7;
  localparam logic [IW-1:0] I_MIN = IW'(2);
  localparam logic [IW-1:0] I_MAX = IW'(15);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t        state, state_next;
  logic [AW-1:0] a_q, a_n;
  logic [IW-1:0] i1_q, i1_n, i2_q, i2_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          found_n;
  logic [IW-1:0] ri1_n, ri2_n;
  logic [CW-1:0] rcnt_n;
  logic [AW-1:0] prod;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] i1_inc;

  // Next-state and datapath decisions
  always_comb begin
    state_next = state;
    a_n        = a_q;
    i1_n       = i1_q;
    i2_n       = i2_q;
    cnt_n      = cnt_q;
    found_n    = rsp_found;
    ri1_n      = rsp_i1;
    ri2_n      = rsp_i2;
    rcnt_n     = rsp_count;
    prod       = AW'(i1_q) * AW'(i2_q);
    cnt_inc    = CW'(cnt_q + CW'(1));
    i1_inc     = IW'(i1_q + IW'(1));

    case (state)
      IDLE: begin
        if (req_valid) begin
          a_n        = req_a;
          i1_n       = I_MIN;
          i2_n       = I_MIN;
          cnt_n      = '0;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        cnt_n = cnt_inc;
        if (prod == a_q) begin
          found_n    = 1'b1;
          ri1_n      = i1_q;
          ri2_n      = i2_q;
          rcnt_n     = cnt_inc;
          state_next = RESP;
        end
`ifdef FACT_SEARCH_EARLY_EXIT_EN
        // Products only grow along i2 and along the diagonal, so stop early
        else if (prod > a_q) begin
          if (i2_q == i1_q) begin
            found_n    = 1'b0;
            ri1_n      = '0;
            ri2_n      = '0;
            rcnt_n     = cnt_inc;
            state_next = RESP;
          end else begin
            i1_n = i1_inc;
            i2_n = i1_inc;
          end
        end
`endif
        else if (i2_q == I_MAX) begin
          if (i1_q == I_MAX) begin
            found_n    = 1'b0;
            ri1_n      = '0;
            ri2_n      = '0;
            rcnt_n     = cnt_inc;
            state_next = RESP;
          end else begin
            i1_n = i1_inc;
            i2_n = i1_inc;
          end
        end else begin
          i2_n = IW'(i2_q + IW'(1));
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      i1_q      <= I_MIN;
      i2_q      <= I_MIN;
      cnt_q     <= '0;
      rsp_found <= 1'b0;
      rsp_i1    <= '0;
      rsp_i2    <= '0;
      rsp_count <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      a_q       <= a_n;
      i1_q      <= i1_n;
      i2_q      <= i2_n;
      cnt_q     <= cnt_n;
      rsp_found <= found_n;
      rsp_i1    <= ri1_n;
      rsp_i2    <= ri2_n;
      rsp_count <= rcnt_n;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      busy      <= (state_next == SEARCH);
    end
  end

endmodule

// File: tb/tb_fact_search.sv
// Randomized self-checking bench for fact_search against a loop-based factor search model.
// Define FACT_SEARCH_EARLY_EXIT_EN for both files to check the pruned configuration.
module tb_fact_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_found;
  logic [3:0] rsp_i1;
  logic [3:0] rsp_i2;
  logic [6:0] rsp_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fact_search dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_found(rsp_found), .rsp_i1(rsp_i1), .rsp_i2(rsp_i2),
    .rsp_count(rsp_count), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef FACT_SEARCH_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk the candidate triangle in order, count evaluations
  task automatic model(input int a, output int found, output int f1, output int f2, output int n);
    found = 0; f1 = 0; f2 = 0; n = 0;
    for (int x = 2; x <= 15; x++) begin
      for (int y = x; y <= 15; y++) begin
        n++;
        if (x * y == a) begin
          found = 1; f1 = x; f2 = y;
          return;
        end
        if (EARLY && x * y > a) begin
          if (y == x) return;
          break;
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 1);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_found"}, int'(rsp_found), 0);
    check({tag, "_i1"}, int'(rsp_i1), 0);
    check({tag, "_i2"}, int'(rsp_i2), 0);
    check({tag, "_count"}, int'(rsp_count), 0);
  endtask

  // Issue one request, check latency, response, hold stability and post-handshake hold
  task automatic run_req(input int a, input int hold);
    int found, f1, f2, n, cyc;
    model(a, found, f1, f2, n);
    req_valid = 1'b1;
    req_a     = 8'(a);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = 8'($urandom_range(0, 255));
    check("search_busy", int'(busy), 1);
    check("search_req_ready", int'(req_ready), 0);
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin
      req_valid = 1'(cyc % 3 == 1);
      req_a     = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    check($sformatf("latency_a%0d", a), cyc, n);
    if (!rsp_valid) begin
      $display("FAIL timeout waiting for rsp_valid, a=%0d", a);
      errors++;
      return;
    end
    check($sformatf("found_a%0d", a), int'(rsp_found), found);
    check($sformatf("i1_a%0d", a), int'(rsp_i1), f1);
    check($sformatf("i2_a%0d", a), int'(rsp_i2), f2);
    check($sformatf("count_a%0d", a), int'(rsp_count), n);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_a     = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_req_ready", int'(req_ready), 0);
      check("hold_i1", int'(rsp_i1), f1);
      check("hold_i2", int'(rsp_i2), f2);
      check("hold_count", int'(rsp_count), n);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", int'(rsp_valid), 0);
    check("post_req_ready", int'(req_ready), 1);
    check("post_busy", int'(busy), 0);
    check("post_found", int'(rsp_found), found);
    check("post_count", int'(rsp_count), n);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 8'd0;
    rsp_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(15, 0);
    run_req(13, 1);
    run_req(0, 0);
    run_req(225, 2);
    run_req(12, 5);
    run_req(1, 0);
    run_req(255, 0);

    // Abort during the third SEARCH cycle, then rerun the same request
    req_valid = 1'b1;
    req_a     = 8'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rsp", int'(rsp_valid), 0);
    run_req(15, 1);

    for (int k = 0; k < 25; k++) begin
      int a;
      if (k % 2 == 0) a = $urandom_range(2, 15) * $urandom_range(2, 15);
      else            a = $urandom_range(0, 255);
      run_req(a, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
